i2s_audio_in: RTL and testbench
===============================

I2S_AUDIO_IN -- requirements
Module: i2s_audio_in

Interface
REQ-001 Parameter: BIT_WIDTH, 24, sample bits captured per channel slot, MSB first (legal 8..32).
REQ-002 Port: sck  input  1  serial bit clock; all logic on posedge sck.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: ws  input  1  word select; 0 = left slot, 1 = right slot.
REQ-005 Port: sd  input  1  serial data from transmitter/microphone.
REQ-006 Port: sample_ready  input  1  consumer accepts held sample when high with sample_valid.
REQ-007 Port: overrun_clr  input  1  clears sticky overrun flag.
REQ-008 Port: sample_out  output  BIT_WIDTH  most recent completed sample.
REQ-009 Port: sample_channel  output  1  channel of sample_out (0 left, 1 right).
REQ-010 Port: sample_valid  output  1  sample_out holds an unconsumed sample.
REQ-011 Port: frame_error  output  1  one-cycle pulse: slot shorter than BIT_WIDTH+1 bits.
REQ-012 Port: overrun  output  1  sticky: completed sample overwrote an unconsumed one.

Function
REQ-013 ws registered every cycle into ws_q; ws edge = (ws != ws_q) at a posedge.
REQ-014 FSM states: SYNC, SHIFT, IGNORE; leaves reset in SYNC.
REQ-015 SYNC: sd ignored; on ws edge -> SHIFT, latch channel = ws, clear bit counter.
REQ-016 I2S one-bit delay: edge detected at posedge k; MSB sampled at posedge k+1; bit i (MSB=0) sampled at posedge k+1+i.
REQ-017 SHIFT: each posedge without ws edge shifts sd into LSB of shift register, increments counter.
REQ-018 On posedge sampling bit BIT_WIDTH-1: sample_out <= full word (MSB first), sample_channel <= latched channel, sample_valid <= 1; FSM -> IGNORE.
REQ-019 Latency: sample_valid high in cycle immediately after LSB sampling edge.
REQ-020 IGNORE: discard sd (trailing slot bits) until ws edge, then -> SHIFT with new channel as in REQ-015.
REQ-021 ws edge in SHIFT before LSB captured: discard partial word, pulse frame_error 1 cycle, restart SHIFT for new channel; sample_out/valid unchanged.
REQ-022 Edge on LSB-sampling cycle itself: counts as REQ-021 (bit not captured as LSB).
REQ-023 Handshake: sample_valid && sample_ready at posedge -> sample_valid <= 0, unless a new sample completes same edge.
REQ-024 New sample completing same edge as accept: load new, sample_valid stays 1, no overrun.
REQ-025 New sample completing while sample_valid=1 and sample_ready=0: newest overwrites, sample_valid stays 1, overrun event.
REQ-026 sample_out, sample_channel stable while sample_valid=1 except on REQ-024/REQ-025 loads.
REQ-027 Consecutive slots back-to-back (slot length exactly BIT_WIDTH+1 bits) legal, no frame_error.

Reset
REQ-028 rst at posedge: FSM -> SYNC, ws_q <= ws, counter and shift register 0, sample_out 0, sample_channel 0, sample_valid 0, frame_error 0, overrun 0.
REQ-029 rst mid-capture aborts word; no valid produced; resynchronise on next ws edge after rst deasserts (edge relative to ws_q captured at reset).

Configuration
REQ-030 Macro I2S_RX_OVERRUN_EN defined: overrun set on REQ-025 event, held until overrun_clr or rst; set wins over simultaneous clear.
REQ-031 Macro I2S_RX_OVERRUN_EN undefined: overrun tied 0, overrun_clr ignored; data overwrite behaviour of REQ-025 unchanged.

Verification (BIT_WIDTH=24, slot 32 bits)
REQ-032 Left 0xA5C3F1 then right 0x123456, sample_ready=1 -> two valid pulses, sample_out 0xA5C3F1/ch0 then 0x123456/ch1, valid cycle after each LSB edge.
REQ-033 rst held, ws constant, sd toggling -> no valid; first ws edge after rst starts capture; preceding bits ignored.
REQ-034 ws edge after 10 bits of right slot -> frame_error one pulse, partial discarded, following left 0x00FF00 captured correctly.
REQ-035 sample_ready=0 over two slots (0x111111, 0x222222) -> sample_out 0x222222, valid=1, overrun=1 (macro on) / 0 (macro off); overrun_clr -> 0.
REQ-036 sample_ready asserted on exact edge next sample completes -> new sample loaded, valid stays 1, overrun stays 0.
REQ-037 rst asserted mid-SHIFT (bit 12) -> all outputs 0 next cycle, FSM SYNC, next full slot captured correctly.

Source files
------------

// File: rtl/i2s_audio_in_if.sv
// Bus between an I2S receiver and its transmitter/consumer side: serial inputs,
// sample handshake and status flags. The clock (sck) and reset stay plain ports.
interface i2s_audio_in_if #(
    parameter int BIT_WIDTH = 24
);
    logic                 ws;
    logic                 sd;
    logic                 sample_ready;
    logic                 overrun_clr;
    logic [BIT_WIDTH-1:0] sample_out;
    logic                 sample_channel;
    logic                 sample_valid;
    logic                 frame_error;
    logic                 overrun;

    // The master side drives the serial line and consumes samples.
    modport master (
        output ws, sd, sample_ready, overrun_clr,
        input  sample_out, sample_channel, sample_valid, frame_error, overrun
    );

    modport slave (
        input  ws, sd, sample_ready, overrun_clr,
        output sample_out, sample_channel, sample_valid, frame_error, overrun
    );
endinterface

// File: rtl/i2s_audio_in.sv
// I2S receiver: deserialises MSB-first slots with the one-bit I2S delay and holds
// each word for a valid/ready consumer. Define I2S_RX_OVERRUN_EN for the sticky overrun flag.
module i2s_audio_in #(
    parameter int BIT_WIDTH = 24
) (
    input  logic           sck,
    input  logic           rst,
    i2s_audio_in_if.slave  bus
);

    localparam int CNT_W = $clog2(BIT_WIDTH);

    typedef enum logic [1:0] {
        SYNC,
        SHIFT,
        IGNORE
    } state_t;

    state_t                 state;
    logic                   ws_q;
    logic [CNT_W-1:0]       bit_cnt;
    logic [BIT_WIDTH-2:0]   shreg;
    logic                   chan;
    logic [BIT_WIDTH-1:0]   out_data;
    logic                   out_chan;
    logic                   out_vld;
    logic                   err_pulse;
    logic                   ovr_flag;

    logic                   ws_edge;
    logic                   lsb_edge;
    logic                   complete;
    logic                   accept;
    logic                   overwrite;

    // The LSB is never stored in the shift register; it joins the word on the fly.
    function automatic logic [BIT_WIDTH-1:0] assemble(
        input logic [BIT_WIDTH-2:0] upper,
        input logic                 lsb
    );
        return {upper, lsb};
    endfunction

    always_comb begin
        ws_edge   = (bus.ws != ws_q);
        lsb_edge  = (state == SHIFT) && (bit_cnt == CNT_W'(BIT_WIDTH - 1));
        complete  = lsb_edge && !ws_edge;
        accept    = out_vld && bus.sample_ready;
        overwrite = complete && out_vld && !bus.sample_ready;
    end

    // ---- slot framing, capture and output hold ----
    always_ff @(posedge sck) begin
        ws_q <= bus.ws;
        if (rst) begin
            state     <= SYNC;
            bit_cnt   <= '0;
            shreg     <= '0;
            chan      <= 1'b0;
            out_data  <= '0;
            out_chan  <= 1'b0;
            out_vld   <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                SYNC, IGNORE: begin
                    if (ws_edge) begin
                        state   <= SHIFT;
                        chan    <= bus.ws;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end
                end
                SHIFT: begin
                    // A ws edge before the LSB is taken (including on the LSB edge
                    // itself) means a short slot: drop the partial word and restart.
                    if (ws_edge) begin
                        err_pulse <= 1'b1;
                        chan      <= bus.ws;
                        bit_cnt   <= '0;
                        shreg     <= '0;
                    end else if (lsb_edge) begin
                        state   <= IGNORE;
                        bit_cnt <= '0;
                    end else begin
                        shreg   <= {shreg[BIT_WIDTH-3:0], bus.sd};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: state <= SYNC;
            endcase

            // A completing word always wins over an accept on the same edge.
            if (complete) begin
                out_data <= assemble(shreg, bus.sd);
                out_chan <= chan;
                out_vld  <= 1'b1;
            end else if (accept) begin
                out_vld <= 1'b0;
            end
        end
    end

`ifdef I2S_RX_OVERRUN_EN
    // ---- sticky overrun: a new overwrite beats a simultaneous clear ----
    always_ff @(posedge sck) begin
        if (rst) begin
            ovr_flag <= 1'b0;
        end else if (overwrite) begin
            ovr_flag <= 1'b1;
        end else if (bus.overrun_clr) begin
            ovr_flag <= 1'b0;
        end
    end
`else
    logic unused_ovr;
    assign ovr_flag   = 1'b0;
    assign unused_ovr = &{1'b0, bus.overrun_clr, overwrite};
`endif

    assign bus.sample_out     = out_data;
    assign bus.sample_channel = out_chan;
    assign bus.sample_valid   = out_vld;
    assign bus.frame_error    = err_pulse;
    assign bus.overrun        = ovr_flag;

endmodule

// File: tb/tb_i2s_audio_in.sv
// Directed scoreboard bench for i2s_audio_in (BIT_WIDTH=24, 32-bit slots unless noted).
module tb_i2s_audio_in;

    logic sck;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   fe_cnt;

    typedef struct {
        logic [23:0] data;
        logic        ch;
        int          cyc;
    } exp_t;

    exp_t q[$];

    i2s_audio_in_if #(.BIT_WIDTH(24)) bus ();

    i2s_audio_in #(.BIT_WIDTH(24)) dut (
        .sck (sck),
        .rst (rst),
        .bus (bus)
    );

    initial sck = 1'b0;
    always #5 sck = ~sck;

    initial cyc = 0;
    always @(posedge sck) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; the following rising edge samples them.
    task automatic step(input logic w, input logic d);
        @(negedge sck);
        bus.ws = w;
        bus.sd = d;
    endtask

    // Slot: position 0 carries the ws edge, positions 1..24 the word MSB first,
    // the rest is filler. push queues the word with its expected valid cycle.
    task automatic send_slot(input logic ch, input logic [23:0] w, input int len,
                             input bit push, input int ready_at);
        for (int p = 0; p < len; p++) begin
            logic d;
            if (p == 0)       d = ~w[23];
            else if (p <= 24) d = w[24-p];
            else              d = p[0];
            step(ch, d);
            if (p == ready_at) bus.sample_ready = 1'b1;
            if (push && p == 24) q.push_back('{w, ch, cyc + 1});
        end
    endtask

    // Monitor: pops an expected word on every accepted handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge sck);
            #1;
            if (bus.frame_error === 1'b1) fe_cnt++;
            if (bus.sample_valid === 1'b1 && bus.sample_ready === 1'b1) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_sample: actual %0h/ch%0d required none",
                             bus.sample_out, bus.sample_channel);
                end else begin
                    e = q.pop_front();
                    check("sample_data", 64'(bus.sample_out), 64'(e.data));
                    check("sample_channel", 64'(bus.sample_channel), 64'(e.ch));
                    if (e.cyc != 0) check("valid_latency", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        logic exp_ovr;
`ifdef I2S_RX_OVERRUN_EN
        exp_ovr = 1'b1;
`else
        exp_ovr = 1'b0;
`endif
        n_checks = 0;
        n_fail   = 0;
        fe_cnt   = 0;
        rst      = 1'b1;
        bus.ws           = 1'b1;
        bus.sd           = 1'b0;
        bus.sample_ready = 1'b1;
        bus.overrun_clr  = 1'b0;

        // Reset held with ws constant and sd toggling
        for (int i = 0; i < 6; i++) step(1'b1, i[0]);
        #1;
        check("rst_valid", 64'(bus.sample_valid), 64'd0);
        check("rst_data", 64'(bus.sample_out), 64'd0);
        check("rst_channel", 64'(bus.sample_channel), 64'd0);
        check("rst_frame_error", 64'(bus.frame_error), 64'd0);
        check("rst_overrun", 64'(bus.overrun), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b1, i[0]);
        #1;
        check("no_valid_before_edge", 64'(bus.sample_valid), 64'd0);

        // Basic left/right capture
        send_slot(1'b0, 24'hA5C3F1, 32, 1'b1, -1);
        send_slot(1'b1, 24'h123456, 32, 1'b1, -1);
        send_slot(1'b0, 24'h5A5A5A, 32, 1'b1, -1);

        // Short right slot (10 bits), then a clean left slot
        send_slot(1'b1, 24'hFFFFFF, 11, 1'b0, -1);
        send_slot(1'b0, 24'h00FF00, 32, 1'b1, -1);
        check("frame_error_short", 64'(fe_cnt), 64'd1);

        // Back-to-back minimum-length slots
        send_slot(1'b1, 24'h00000F, 25, 1'b1, -1);
        send_slot(1'b0, 24'hFFFFFE, 25, 1'b1, -1);
        check("frame_error_min_slot", 64'(fe_cnt), 64'd1);

        // ws edge lands on the LSB edge: word dropped, frame_error
        send_slot(1'b1, 24'hABCDEF, 24, 1'b0, -1);
        send_slot(1'b0, 24'h800001, 32, 1'b1, -1);
        check("frame_error_lsb_edge", 64'(fe_cnt), 64'd2);

        // Consumer stalled across two slots: newest overwrites
        bus.sample_ready = 1'b0;
        send_slot(1'b1, 24'h111111, 32, 1'b0, -1);
        #1;
        check("held_valid", 64'(bus.sample_valid), 64'd1);
        check("held_data", 64'(bus.sample_out), 64'h111111);
        check("held_channel", 64'(bus.sample_channel), 64'd1);
        send_slot(1'b0, 24'h222222, 32, 1'b0, -1);
        #1;
        check("overwrite_data", 64'(bus.sample_out), 64'h222222);
        check("overwrite_channel", 64'(bus.sample_channel), 64'd0);
        check("overwrite_valid", 64'(bus.sample_valid), 64'd1);
        check("overrun_set", 64'(bus.overrun), 64'(exp_ovr));
        step(1'b0, 1'b0);
        bus.overrun_clr = 1'b1;
        step(1'b0, 1'b0);
        bus.overrun_clr = 1'b0;
        #1;
        check("overrun_cleared", 64'(bus.overrun), 64'd0);
        q.push_back('{24'h222222, 1'b0, 0});
        bus.sample_ready = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        // Accept on the very edge the next word completes
        bus.sample_ready = 1'b0;
        send_slot(1'b1, 24'h333333, 32, 1'b0, -1);
        q.push_back('{24'h333333, 1'b1, 0});
        send_slot(1'b0, 24'h444444, 32, 1'b1, 24);
        #1;
        check("accept_same_edge_overrun", 64'(bus.overrun), 64'd0);

        // Reset mid-capture at bit 12
        send_slot(1'b1, 24'h777777, 13, 1'b0, -1);
        rst = 1'b1;
        step(1'b1, 1'b1);
        rst = 1'b0;
        #1;
        check("midrst_valid", 64'(bus.sample_valid), 64'd0);
        check("midrst_data", 64'(bus.sample_out), 64'd0);
        check("midrst_channel", 64'(bus.sample_channel), 64'd0);
        check("midrst_overrun", 64'(bus.overrun), 64'd0);
        for (int i = 0; i < 4; i++) step(1'b1, i[0]);
        send_slot(1'b0, 24'h5AA5C3, 32, 1'b1, -1);
        send_slot(1'b1, 24'h000001, 32, 1'b1, -1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        #1;
        check("queue_drained", 64'(q.size()), 64'd0);
        check("frame_error_total", 64'(fe_cnt), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
